// File: rtl/stopwatch_lap.sv
// stopwatch_lap: count-up mm:ss BCD stopwatch
// with start/pause, lap freeze, clear and wrap flag.
module stopwatch_lap #(
  parameter int MAX_MIN = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start_p,
  input  logic       lap_p,
  input  logic       clr_p,
  output logic [3:0] s0,
  output logic [3:0] s1,
  output logic [3:0] m0,
  output logic [3:0] m1,
  output logic [3:0] blink,
  output logic       running,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SPLIT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [3:0] MM1 = 4'(MAX_MIN / 10);
  localparam logic [3:0] MM0 = 4'(MAX_MIN % 10);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_cnt;
  logic [15:0] r_lap;
  logic        r_ovf;
  logic [15:0] w_inc;
  logic        w_wrap;
  logic        w_count;
  logic        w_clr;
  logic        w_start;
  logic        w_lap;
  logic        w_zero;
  logic        w_capture;
  logic [15:0] w_disp;

  // Only the highest-priority pulse of a cycle is seen.
  assign w_clr   = clr_p;
  assign w_start = start_p & ~clr_p;
  assign w_lap   = lap_p & ~start_p & ~clr_p;

  assign w_count   = tick &
                     ((r_state == RUN) ||
                      (r_state == SPLIT));
  assign w_zero    = (r_state == HOLD) && w_clr;
  assign w_capture = (r_state == RUN) && w_lap;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode from the filtered pulses.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_start) w_next = RUN;
      end
      RUN: begin
        if (w_start)    w_next = HOLD;
        else if (w_lap) w_next = SPLIT;
      end
      SPLIT: begin
        if (w_start)    w_next = HOLD;
        else if (w_lap) w_next = RUN;
      end
      HOLD: begin
        if (w_clr)        w_next = IDLE;
        else if (w_start) w_next = RUN;
      end
      default: w_next = IDLE;
    endcase
  end

  // One-second BCD increment with minute wrap.
  always_comb begin
    w_inc  = r_cnt;
    w_wrap = 1'b0;
    if (r_cnt[3:0] != 4'd9) begin
      w_inc[3:0] = r_cnt[3:0] + 4'd1;
    end else begin
      w_inc[3:0] = 4'd0;
      if (r_cnt[7:4] != 4'd5) begin
        w_inc[7:4] = r_cnt[7:4] + 4'd1;
      end else begin
        w_inc[7:4] = 4'd0;
        if (r_cnt[15:8] == {MM1, MM0}) begin
          w_inc[15:8] = 8'd0;
          w_wrap      = 1'b1;
        end else if (r_cnt[11:8] != 4'd9) begin
          w_inc[11:8] = r_cnt[11:8] + 4'd1;
        end else begin
          w_inc[11:8]  = 4'd0;
          w_inc[15:12] = r_cnt[15:12] + 4'd1;
        end
      end
    end
  end

  // Live counter: cleared from HOLD, else counts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_cnt <= 16'd0;
    else if (w_zero)  r_cnt <= 16'd0;
    else if (w_count) r_cnt <= w_inc;
  end

  // Split latch takes the pre-increment value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_lap <= 16'd0;
    else if (w_zero)    r_lap <= 16'd0;
    else if (w_capture) r_lap <= r_cnt;
  end

  // Sticky wrap flag, dropped only by clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_ovf <= 1'b0;
    else if (w_zero)           r_ovf <= 1'b0;
    else if (w_count & w_wrap) r_ovf <= 1'b1;
  end

  assign w_disp = (r_state == SPLIT) ? r_lap : r_cnt;

  assign s0      = w_disp[3:0];
  assign s1      = w_disp[7:4];
  assign m0      = w_disp[11:8];
  assign m1      = w_disp[15:12];
  assign running = (r_state == RUN) ||
                   (r_state == SPLIT);
  assign ovf     = r_ovf;

  // Blink pattern; wrap flag outranks the pause flash.
  always_comb begin
    blink = 4'b0000;
    if (r_state == SPLIT)     blink = 4'b1111;
    else if (r_ovf)           blink = 4'b1100;
    else if (r_state == HOLD) blink = 4'b0011;
  end

endmodule

// File: tb/tb_stopwatch_lap.sv
// tb_stopwatch_lap: table-driven directed bench
// plus hand-written reset corner cases.
module tb_stopwatch_lap;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       start_p = 1'b0;
  logic       lap_p = 1'b0;
  logic       clr_p = 1'b0;
  logic [3:0] s0, s1, m0, m1;
  logic [3:0] blink;
  logic       running;
  logic       ovf;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clk = ~clk;

  stopwatch_lap #(.MAX_MIN(59)) dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .start_p (start_p),
    .lap_p   (lap_p),
    .clr_p   (clr_p),
    .s0      (s0),
    .s1      (s1),
    .m0      (m0),
    .m1      (m1),
    .blink   (blink),
    .running (running),
    .ovf     (ovf)
  );

  typedef struct {
    int          reps;
    logic        t;
    logic        s;
    logic        l;
    logic        c;
    logic [15:0] d;
    logic [3:0]  b;
    logic        chkb;
    logic        run;
    logic        ov;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(
    input int n, input logic t, input logic s,
    input logic l, input logic c,
    input logic [15:0] d, input logic [3:0] b,
    input logic chkb, input logic run,
    input logic ov);
    vec_t v;
    v.reps = n; v.t = t; v.s = s;
    v.l = l; v.c = c; v.d = d; v.b = b;
    v.chkb = chkb; v.run = run; v.ov = ov;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  task automatic chk_all(input string tag,
                         input logic [15:0] d,
                         input logic [3:0] b,
                         input logic chkb,
                         input logic run,
                         input logic ov);
    chk({tag, " digits"}, {m1, m0, s1, s0}, d);
    if (chkb) chk({tag, " blink"}, {12'd0, blink},
                  {12'd0, b});
    chk({tag, " running"}, {15'd0, running},
        {15'd0, run});
    chk({tag, " ovf"}, {15'd0, ovf}, {15'd0, ov});
  endtask

  task automatic drive(input int n, input logic t,
                       input logic s, input logic l,
                       input logic c);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      tick = t; start_p = s; lap_p = l; clr_p = c;
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    // n  t  s  l  c  digits   blink  cb run ovf
    add(1, 0, 0, 0, 0, 16'h0000, 4'h0, 1, 0, 0);
    add(1, 0, 0, 1, 0, 16'h0000, 4'h0, 1, 0, 0);
    add(1, 0, 0, 0, 1, 16'h0000, 4'h0, 1, 0, 0);
    add(1, 1, 1, 0, 0, 16'h0000, 4'h0, 1, 1, 0);
    add(1, 1, 0, 0, 0, 16'h0001, 4'h0, 1, 1, 0);
    add(74, 1, 0, 0, 0, 16'h0115, 4'h0, 1, 1, 0);
    add(1, 0, 1, 0, 0, 16'h0115, 4'h3, 1, 0, 0);
    add(3, 1, 0, 0, 0, 16'h0115, 4'h3, 1, 0, 0);
    add(1, 0, 1, 0, 1, 16'h0000, 4'h0, 1, 0, 0);
    add(1, 0, 1, 0, 0, 16'h0000, 4'h0, 1, 1, 0);
    add(10, 1, 0, 0, 0, 16'h0010, 4'h0, 1, 1, 0);
    add(1, 0, 0, 0, 1, 16'h0010, 4'h0, 1, 1, 0);
    add(1, 0, 0, 1, 0, 16'h0010, 4'hf, 1, 1, 0);
    add(1, 0, 0, 0, 1, 16'h0010, 4'hf, 1, 1, 0);
    add(5, 1, 0, 0, 0, 16'h0010, 4'hf, 1, 1, 0);
    add(1, 0, 0, 1, 0, 16'h0015, 4'h0, 1, 1, 0);
    add(1, 1, 0, 1, 0, 16'h0015, 4'hf, 1, 1, 0);
    add(1, 1, 1, 0, 0, 16'h0017, 4'h3, 1, 0, 0);
    add(1, 0, 1, 0, 0, 16'h0017, 4'h0, 1, 1, 0);
    add(133, 1, 0, 0, 0, 16'h0230, 4'h0, 1, 1, 0);
    add(1, 0, 1, 0, 0, 16'h0230, 4'h3, 1, 0, 0);
    add(2, 1, 0, 0, 0, 16'h0230, 4'h3, 1, 0, 0);
    add(1, 0, 1, 0, 1, 16'h0000, 4'h0, 1, 0, 0);
    add(1, 0, 1, 0, 0, 16'h0000, 4'h0, 1, 1, 0);
    add(599, 1, 0, 0, 0, 16'h0959, 4'h0, 1, 1, 0);
    add(1, 1, 0, 0, 0, 16'h1000, 4'h0, 1, 1, 0);
    add(2999, 1, 0, 0, 0, 16'h5959, 4'h0, 1, 1, 0);
    add(1, 1, 0, 0, 0, 16'h0000, 4'hc, 1, 1, 1);
    add(1, 1, 0, 0, 0, 16'h0001, 4'hc, 1, 1, 1);
    add(1, 0, 1, 1, 0, 16'h0001, 4'h0, 0, 0, 1);
    add(1, 0, 0, 0, 1, 16'h0000, 4'h0, 1, 0, 0);

    #23;
    chk_all("reset", 16'h0000, 4'h0, 1, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].reps, vecs[i].t, vecs[i].s,
            vecs[i].l, vecs[i].c);
      chk_all($sformatf("row%0d", i), vecs[i].d,
              vecs[i].b, vecs[i].chkb,
              vecs[i].run, vecs[i].ov);
    end

    drive(1, 0, 1, 0, 0);
    drive(3, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 0);
    drive(2, 1, 0, 0, 0);
    chk_all("pre_rst", 16'h0003, 4'hf, 1, 1, 0);
    @(negedge clk);
    tick = 1'b0; start_p = 1'b0;
    lap_p = 1'b0; clr_p = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 16'h0000, 4'h0, 1, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 1, 0, 0);
    drive(1, 0, 0, 1, 0);
    chk_all("post_rst", 16'h0000, 4'hf, 1, 1, 0);
    drive(1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/stopwatch_lap.md
# stopwatch_lap

Count-up mm:ss stopwatch with start/pause, lap (split) freeze and clear. It counts BCD digits directly, so no binary-to-BCD divider is needed. Its outputs feed the same four 7-segment-with-blink digit drivers used by the countdown timer. All control inputs are already-debounced single-cycle pulses. The 1 Hz `tick` comes from the shared variable clock divider.

## Interface
- `MAX_MIN`, default 59: highest minute value (0..99, decimal) before wrap to 00:00.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tick`  in  1  one-cycle count-enable pulse, nominally 1 Hz.
- `start_p`  in  1  start/pause pulse.
- `lap_p`  in  1  split/resume-live-display pulse.
- `clr_p`  in  1  clear pulse.
- `s0`, `s1`, `m0`, `m1`  out  4 each  displayed BCD digits: sec units, sec tens, min units, min tens.
- `blink`  out  4  per-digit blink enables, bit order {m1,m0,s1,s0}.
- `running`  out  1  high while the counter advances (RUN or SPLIT).
- `ovf`  out  1  sticky flag: the counter wrapped past MAX_MIN:59.

## Operation
- Internal state: 2-bit FSM {IDLE, RUN, SPLIT, HOLD}, 16-bit BCD live counter, 16-bit BCD split latch, `ovf` register.
- Pulse priority when several arrive in one cycle: `clr_p` > `start_p` > `lap_p`. Lower-priority pulses in that cycle are dropped.
- IDLE (counter 00:00):
  - `start_p` → RUN.
  - `lap_p` and `clr_p` have no effect.
- RUN:
  - `start_p` → HOLD.
  - `lap_p` → SPLIT and copies the live counter into the split latch in the same edge.
  - `clr_p` is ignored.
- SPLIT:
  - The counter keeps advancing; the display shows the split latch.
  - `lap_p` → RUN (live display).
  - `start_p` → HOLD (live display, counting stops).
  - `clr_p` is ignored.
- HOLD:
  - `start_p` → RUN.
  - `clr_p` → IDLE: zeroes the counter and split latch, clears `ovf`.
  - `lap_p` is ignored.
- Counting rule: the counter increments on an edge where the current registered state is RUN or SPLIT and `tick`=1.
  - Gating uses the current state, so `tick` coincident with `start_p` in IDLE is not counted.
  - `tick` coincident with `start_p` in RUN is counted (the final second before pause).
- BCD increment:
  - `s0` 9→0 carries into `s1`.
  - `s1` 5→0 carries into minutes.
  - `m0` 9→0 carries into `m1`.
  - Minute wrap: when {m1,m0} equals MAX_MIN in BCD and the seconds carry, the counter becomes 00:00 and `ovf` is set. Counting continues.
- Digit values never leave their legal range: s1 0..5, the others 0..9, minutes ≤ MAX_MIN.
- Display mux: the digits show the split latch in SPLIT and the live counter otherwise.
- `blink`:
  - 4'b1111 in SPLIT.
  - 4'b0011 in HOLD (the paused seconds flash).
  - 4'b1100 in any state while `ovf`=1 and not SPLIT.
  - 4'b0000 otherwise.
- `running` = state is RUN or SPLIT.

## Timing
- Reset values: state IDLE; counter, latch and all digits 0; `blink` 4'b0000; `running` 0; `ovf` 0.
- Reset acts asynchronously at any point, including mid-count or in SPLIT, and returns everything to the reset values.
- All outputs are driven from registers through a state-selected mux; no input-to-output combinational path.
- Latency:
  - A control pulse at edge N changes state, `running` and `blink` after edge N.
  - A counted `tick` at edge N shows the new live digits after edge N, unless in SPLIT.
  - A lap capture at edge N holds the digits as they stood before that edge's increment.
- `tick` may arrive every cycle; each pulse advances the counter by exactly one second.
- A pulse held for several cycles acts once per cycle it is high; upstream guarantees single-cycle pulses.

## Test plan
- **Reset, start, count:** reset, then `start_p`, then 75 `tick` pulses. Expect digits 01:15, `running`=1, `blink`=0000.
- **Same-cycle start and tick:** `start_p` with `tick` in the same cycle from IDLE. Expect 00:00; the next `tick` gives 00:01.
- **Split:** at 00:10 in RUN, `lap_p`, then 5 ticks. Display stays 00:10 with `blink`=1111. Then `lap_p`: display 00:15, `blink`=0000.
- **Pause and clear:**
  - At 02:30 in RUN, `start_p`: HOLD, `blink`=0011; ticks ignored.
  - `clr_p` with `start_p` in the same cycle: IDLE, 00:00 (clear wins).
- **Wrap:** run to 59:59 with MAX_MIN=59, then 1 tick. Expect 00:00, `ovf`=1, `blink`=1100, still counting. `start_p` then `clr_p` clears `ovf`.
- **Mid-operation reset:** `rst` asserted in SPLIT between edges. All outputs return to reset values immediately, without waiting for a clock edge.
